// File: rtl/register_file_8.sv
// Register file with one write port and two registered read ports (A to the shifter, B to
// the data output). A same-cycle write is forwarded to a read of the same address.
module register_file_8 #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 2
) (
    input  logic                       clk,
    input  logic                       reset_n,
    input  logic [DATA_WIDTH-1:0]      from_mux,
    input  logic                       write_enable,
    input  logic [ADDR_WIDTH-1:0]      write_address,
    input  logic                       read_enable_a,
    input  logic [ADDR_WIDTH-1:0]      read_address_a,
    input  logic                       read_enable_b,
    input  logic [ADDR_WIDTH-1:0]      read_address_b,
    output logic [DATA_WIDTH-1:0]      to_shifter,
    output logic                       valid_a,
    output logic [DATA_WIDTH-1:0]      output_data,
    output logic                       valid_b,
    output logic [(2**ADDR_WIDTH)-1:0] written_map
);

    localparam int DEPTH = 2 ** ADDR_WIDTH;

    logic [DATA_WIDTH-1:0] regs_reg [DEPTH];
    logic [DEPTH-1:0]      written_reg;
    logic [DATA_WIDTH-1:0] data_a_reg, data_a_next;
    logic [DATA_WIDTH-1:0] data_b_reg, data_b_next;
    logic                  valid_a_reg, valid_b_reg;

    genvar gi;
    generate
        for (gi = 0; gi < DEPTH; gi++) begin : g_reg
            always_ff @(posedge clk) begin
                if (!reset_n) begin
                    regs_reg[gi]    <= '0;
                    written_reg[gi] <= 1'b0;
                end else if (write_enable && (write_address == ADDR_WIDTH'(gi))) begin
                    regs_reg[gi]    <= from_mux;
                    written_reg[gi] <= 1'b1;
                end
            end
        end
    endgenerate

    // Write-first: a read of the address being written sees the incoming bus value.
    always_comb begin
        data_a_next = regs_reg[read_address_a];
        data_b_next = regs_reg[read_address_b];
        if (write_enable && (write_address == read_address_a)) begin
            data_a_next = from_mux;
        end
        if (write_enable && (write_address == read_address_b)) begin
            data_b_next = from_mux;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            data_a_reg  <= '0;
            data_b_reg  <= '0;
            valid_a_reg <= 1'b0;
            valid_b_reg <= 1'b0;
        end else begin
            valid_a_reg <= read_enable_a;
            valid_b_reg <= read_enable_b;
            if (read_enable_a) begin
                data_a_reg <= data_a_next;
            end
            if (read_enable_b) begin
                data_b_reg <= data_b_next;
            end
        end
    end

    assign to_shifter  = data_a_reg;
    assign valid_a     = valid_a_reg;
    assign output_data = data_b_reg;
    assign valid_b     = valid_b_reg;
    assign written_map = written_reg;

endmodule

// File: tb/tb_register_file_8.sv
// Randomized bench for register_file_8 against an array-based reference model,
// preceded by the directed reset, read, bypass, hold and dual-read scenarios.
module tb_register_file_8;

    logic       clk = 1'b0;
    logic       reset_n;
    logic [7:0] from_mux;
    logic       write_enable;
    logic [1:0] write_address;
    logic       read_enable_a;
    logic [1:0] read_address_a;
    logic       read_enable_b;
    logic [1:0] read_address_b;
    logic [7:0] to_shifter;
    logic       valid_a;
    logic [7:0] output_data;
    logic       valid_b;
    logic [3:0] written_map;

    int tests_run = 0;
    int tests_failed = 0;

    logic [7:0] m_mem [4];
    logic [7:0] m_a, m_b;
    logic       m_va, m_vb;
    logic [3:0] m_map;

    register_file_8 #(.DATA_WIDTH(8), .ADDR_WIDTH(2)) dut (
        .clk(clk),
        .reset_n(reset_n),
        .from_mux(from_mux),
        .write_enable(write_enable),
        .write_address(write_address),
        .read_enable_a(read_enable_a),
        .read_address_a(read_address_a),
        .read_enable_b(read_enable_b),
        .read_address_b(read_address_b),
        .to_shifter(to_shifter),
        .valid_a(valid_a),
        .output_data(output_data),
        .valid_b(valid_b),
        .written_map(written_map)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests_run++;
        if (obs !== exp) begin
            tests_failed++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // One clock cycle: drive inputs, advance the model, compare every output.
    task automatic cycle(input logic rn, input logic we, input logic [1:0] wa, input logic [7:0] d,
                         input logic rea, input logic [1:0] ra, input logic reb, input logic [1:0] rb);
        reset_n        = rn;
        write_enable   = we;
        write_address  = wa;
        from_mux       = d;
        read_enable_a  = rea;
        read_address_a = ra;
        read_enable_b  = reb;
        read_address_b = rb;
        @(posedge clk);
        if (!rn) begin
            for (int i = 0; i < 4; i++) m_mem[i] = 8'h00;
            m_a = 8'h00; m_b = 8'h00; m_va = 1'b0; m_vb = 1'b0; m_map = 4'b0000;
        end else begin
            // Writing before reading gives the write-first result directly.
            if (we) begin
                m_mem[wa]  = d;
                m_map[wa]  = 1'b1;
            end
            if (rea) m_a = m_mem[ra];
            if (reb) m_b = m_mem[rb];
            m_va = rea;
            m_vb = reb;
        end
        #1;
        check("to_shifter", 32'(to_shifter), 32'(m_a));
        check("valid_a", 32'(valid_a), 32'(m_va));
        check("output_data", 32'(output_data), 32'(m_b));
        check("valid_b", 32'(valid_b), 32'(m_vb));
        check("written_map", 32'(written_map), 32'(m_map));
        $display("[TB] t=%0t rn=%0b we=%0b wa=%0d d=%02h ra=%0b/%0d rb=%0b/%0d -> a=%02h va=%0b b=%02h vb=%0b map=%04b",
                 $time, rn, we, wa, d, rea, ra, reb, rb, to_shifter, valid_a, output_data, valid_b, written_map);
    endtask

    initial begin
        // Reset held two cycles while a write of FF is presented.
        cycle(1'b0, 1'b1, 2'd1, 8'hFF, 1'b1, 2'd1, 1'b1, 2'd2);
        cycle(1'b0, 1'b1, 2'd2, 8'hFF, 1'b1, 2'd1, 1'b1, 2'd2);
        check("rst_valid_a", 32'(valid_a), 32'd0);
        check("rst_valid_b", 32'(valid_b), 32'd0);
        check("rst_map", 32'(written_map), 32'd0);

        // Never-written registers read back as zero.
        cycle(1'b1, 1'b0, 2'd0, 8'h00, 1'b1, 2'd1, 1'b1, 2'd0);
        check("unwritten_a", 32'(to_shifter), 32'h00);
        check("unwritten_b", 32'(output_data), 32'h00);

        // Basic write then read.
        cycle(1'b1, 1'b1, 2'd1, 8'hA5, 1'b0, 2'd0, 1'b0, 2'd0);
        cycle(1'b1, 1'b1, 2'd2, 8'h3C, 1'b0, 2'd0, 1'b0, 2'd0);
        cycle(1'b1, 1'b0, 2'd0, 8'h00, 1'b1, 2'd1, 1'b1, 2'd2);
        check("basic_a", 32'(to_shifter), 32'hA5);
        check("basic_b", 32'(output_data), 32'h3C);
        check("basic_va", 32'(valid_a), 32'd1);
        check("basic_vb", 32'(valid_b), 32'd1);
        check("basic_map", 32'(written_map), 32'b0110);

        // Hold: no read keeps data and drops valid.
        cycle(1'b1, 1'b0, 2'd0, 8'h00, 1'b0, 2'd0, 1'b0, 2'd0);
        check("hold_va", 32'(valid_a), 32'd0);
        check("hold_a", 32'(to_shifter), 32'hA5);

        // Bypass on port A.
        cycle(1'b1, 1'b1, 2'd3, 8'h11, 1'b0, 2'd0, 1'b0, 2'd0);
        cycle(1'b1, 1'b1, 2'd3, 8'h7E, 1'b1, 2'd3, 1'b0, 2'd0);
        check("bypass_a", 32'(to_shifter), 32'h7E);

        // Bypass on port B.
        cycle(1'b1, 1'b1, 2'd0, 8'h42, 1'b0, 2'd0, 1'b1, 2'd0);
        check("bypass_b", 32'(output_data), 32'h42);

        // Both ports read the same address.
        cycle(1'b1, 1'b0, 2'd0, 8'h00, 1'b1, 2'd1, 1'b1, 2'd1);
        check("dual_a", 32'(to_shifter), 32'hA5);
        check("dual_b", 32'(output_data), 32'hA5);

        // Random traffic with occasional mid-run reset.
        for (int i = 0; i < 400; i++) begin
            cycle(($urandom_range(0, 39) != 0),
                  1'($urandom), 2'($urandom), 8'($urandom),
                  1'($urandom), 2'($urandom), 1'($urandom), 2'($urandom));
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
